// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receive controller.
// Parity support is selected in uart_rx_ctrl with `UART_RX_PARITY_EN.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count and overrun flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     overrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, pop_ok, push_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign pop_ok  = pop_i && (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_i && (!full || pop_ok);

  assign overrun_o = push_i && full && !pop_ok;
  assign valid_o   = (cnt_q != '0);
  assign cnt_o     = cnt_q;
  assign data_o    = valid_o ? mem_q[rptr_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 16x oversampling framer feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add an odd-parity bit between data and stop.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          uart_rx,
  input  logic [15:0]                   baud_div,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic [15:0] div_q;
  logic [15:0] divcnt_q, divcnt_d;
  logic [3:0]  tickcnt_q, tickcnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, frame_err_q;
  logic        line, tick, tick_mid, tick_last;
  logic        stop_sample, byte_done, parity_ok;

  assign line      = sync_q[1];
  assign tick      = (divcnt_q == div_q);
  assign tick_mid  = (tickcnt_q == 4'(SAMPLE_MID - 1));
  assign tick_last = (tickcnt_q == 4'(OVERSAMPLE - 1));

  assign stop_sample = (state_q == STOP) && tick && tick_last;
  assign byte_done   = stop_sample && line;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, parity_err_q;

  assign parity_ok  = ^{shift_q, par_q};
  assign parity_err = parity_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= byte_done && !parity_ok;
    end
  end
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Holding the divider at zero in IDLE guarantees a clean phase on entry to START.
  always_comb begin
    divcnt_d = divcnt_q + 16'd1;
    if (state_q == IDLE || tick) begin
      divcnt_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tickcnt_d = tickcnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        tickcnt_d = '0;
        bitcnt_d  = '0;
        if (!line) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tickcnt_d = tickcnt_q + 4'd1;
          if (tick_mid) begin
            tickcnt_d = '0;
            state_d   = line ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tickcnt_d = tickcnt_q + 4'd1;
          if (tick_last) begin
            shift_d  = {line, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tickcnt_d = tickcnt_q + 4'd1;
          if (tick_last) begin
            par_d   = line;
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tickcnt_d = tickcnt_q + 4'd1;
          if (tick_last) begin
            state_d = line ? IDLE : BREAK;
          end
        end
      end
      BREAK: begin
        if (line) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      div_q       <= '0;
      divcnt_q    <= '0;
      tickcnt_q   <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_rx};
      state_q     <= state_d;
      divcnt_q    <= divcnt_d;
      tickcnt_q   <= tickcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      push_q      <= byte_done && parity_ok;
      frame_err_q <= stop_sample && !line;
      if (state_q == IDLE) begin
        div_q <= baud_div;
      end
    end
  end

  assign frame_err = frame_err_q;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (push_q),
    .data_i    (shift_q),
    .pop_i     (rx_ready),
    .data_o    (rx_data),
    .valid_o   (rx_valid),
    .cnt_o     (fifo_cnt),
    .overrun_o (overrun)
  );

endmodule
